// File: rtl/cwm_rx_derotator_if.sv
`default_nettype none
// ============================================================================
// Module      : cwm_rx_derotator_if
// Description : Sample stream and phase-control bundle for the RX carrier
//               de-rotator.
//               master : driver side (RX front-end / test source)
//               slave  : de-rotator side
//   phase_load  load phase accumulator with phase_init
//   phase_init  initial phase, 0..2^PHASE_W-1 maps to 0..2*pi
//   freq_word   phase increment per accepted sample
//   in_valid    I_in/Q_in valid this cycle
//   I_in, Q_in  received complex sample (signed)
//   out_valid   I_out/Q_out valid
//   I_out,Q_out de-rotated complex sample (signed)
//   sat_pulse   1-cycle pulse: this valid output saturated
// Revision    : 1.0  initial release
// ============================================================================
interface cwm_rx_derotator_if #(
  parameter int DATA_W  = 18,
  parameter int PHASE_W = 8
);
  logic                      phase_load;
  logic        [PHASE_W-1:0] phase_init;
  logic        [PHASE_W-1:0] freq_word;
  logic                      in_valid;
  logic signed [DATA_W-1:0]  I_in;
  logic signed [DATA_W-1:0]  Q_in;
  logic                      out_valid;
  logic signed [DATA_W-1:0]  I_out;
  logic signed [DATA_W-1:0]  Q_out;
  logic                      sat_pulse;

  modport master (
    output phase_load, phase_init, freq_word, in_valid, I_in, Q_in,
    input  out_valid, I_out, Q_out, sat_pulse
  );

  modport slave (
    input  phase_load, phase_init, freq_word, in_valid, I_in, Q_in,
    output out_valid, I_out, Q_out, sat_pulse
  );
endinterface
`default_nettype wire

// File: rtl/cwm_rx_derotator.sv
`default_nettype none
// ============================================================================
// Module      : cwm_rx_derotator
// Description : Receive-side carrier-phase de-rotator. Each accepted complex
//               sample is multiplied by exp(-j*theta), where theta comes from
//               a phase accumulator (initial phase plus a per-sample frequency
//               word) looked up in a 64-point quarter-wave sin/cos table.
//               Fixed 3-cycle streaming pipeline, no backpressure.
// Ports       : clk  - clock
//               rst  - asynchronous reset, active-low
//               bus  - cwm_rx_derotator_if.slave (phase control, sample in,
//                      de-rotated sample out, saturation pulse)
// Revision    : 1.0  initial release
// ============================================================================
module cwm_rx_derotator #(
  parameter int DATA_W  = 18,
  parameter int PHASE_W = 8,
  parameter int COEF_W  = 6
) (
  input  wire logic          clk,
  input  wire logic          rst,
  cwm_rx_derotator_if.slave  bus
);

  localparam int C_IDX_W = 6;                 // 64-point table
  localparam int PW      = DATA_W + COEF_W;   // product width
  localparam int SW      = PW + 1;            // sum width

  localparam logic signed [SW-1:0] C_RND = SW'(8);
  localparam logic signed [SW-1:0] C_MAX =
    {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] C_MIN =
    {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // First quadrant of round(16*sin(2*pi*idx/64)), idx = 0..16.
  function automatic logic signed [COEF_W-1:0] qwave(input logic [4:0] idx);
    case (idx)
      5'd0:    qwave = COEF_W'(0);
      5'd1:    qwave = COEF_W'(2);
      5'd2:    qwave = COEF_W'(3);
      5'd3:    qwave = COEF_W'(5);
      5'd4:    qwave = COEF_W'(6);
      5'd5:    qwave = COEF_W'(8);
      5'd6:    qwave = COEF_W'(9);
      5'd7:    qwave = COEF_W'(10);
      5'd8:    qwave = COEF_W'(11);
      5'd9:    qwave = COEF_W'(12);
      5'd10:   qwave = COEF_W'(13);
      5'd11:   qwave = COEF_W'(14);
      5'd12:   qwave = COEF_W'(15);
      5'd13:   qwave = COEF_W'(15);
      5'd14:   qwave = COEF_W'(16);
      5'd15:   qwave = COEF_W'(16);
      5'd16:   qwave = COEF_W'(16);
      default: qwave = COEF_W'(0);
    endcase
  endfunction

  // Phase accumulator
  logic        [PHASE_W-1:0] ph_q, ph_d;
  // Stage 1: sample and coefficients
  logic                      s1_valid_q, s1_valid_d;
  logic signed [DATA_W-1:0]  s1_re_q, s1_re_d;
  logic signed [DATA_W-1:0]  s1_im_q, s1_im_d;
  logic signed [COEF_W-1:0]  s1_cos_q, s1_cos_d;
  logic signed [COEF_W-1:0]  s1_sin_q, s1_sin_d;
  // Stage 2: products
  logic                      s2_valid_q, s2_valid_d;
  logic signed [PW-1:0]      s2_ic_q, s2_ic_d;
  logic signed [PW-1:0]      s2_qs_q, s2_qs_d;
  logic signed [PW-1:0]      s2_qc_q, s2_qc_d;
  logic signed [PW-1:0]      s2_is_q, s2_is_d;
  // Stage 3: outputs
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  i_out_q, i_out_d;
  logic signed [DATA_W-1:0]  q_out_q, q_out_d;
  logic                      sat_q, sat_d;

  // Combinational helpers
  logic        [PHASE_W-1:0] ph_use;
  logic        [C_IDX_W-1:0] k;
  logic        [3:0]         r;
  logic signed [COEF_W-1:0]  t_r, t_rc;
  logic signed [COEF_W-1:0]  cos_w, sin_w;
  logic signed [SW-1:0]      sum_a, sum_b, rnd_a, rnd_b;

  always_comb begin
    ph_d        = ph_q;
    s1_valid_d  = bus.in_valid;
    s1_re_d     = s1_re_q;
    s1_im_d     = s1_im_q;
    s1_cos_d    = s1_cos_q;
    s1_sin_d    = s1_sin_q;
    s2_valid_d  = s1_valid_q;
    s2_ic_d     = s2_ic_q;
    s2_qs_d     = s2_qs_q;
    s2_qc_d     = s2_qc_q;
    s2_is_d     = s2_is_q;
    out_valid_d = s2_valid_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    sat_d       = 1'b0;

    // A load in the same cycle as a sample applies to that sample.
    ph_use = bus.phase_load ? bus.phase_init : ph_q;
    if (bus.phase_load) begin
      ph_d = bus.in_valid ? (bus.phase_init + bus.freq_word) : bus.phase_init;
    end else if (bus.in_valid) begin
      ph_d = ph_q + bus.freq_word;
    end

    // Table index is the top C_IDX_W bits of the phase.
    k    = C_IDX_W'(ph_use >> (PHASE_W - C_IDX_W));
    r    = k[3:0];
    t_r  = qwave({1'b0, r});
    t_rc = qwave(5'd16 - {1'b0, r});
    case (k[5:4])
      2'd0:    begin cos_w =  t_rc; sin_w =  t_r;  end
      2'd1:    begin cos_w = -t_r;  sin_w =  t_rc; end
      2'd2:    begin cos_w = -t_rc; sin_w = -t_r;  end
      default: begin cos_w =  t_r;  sin_w = -t_rc; end
    endcase

    if (bus.in_valid) begin
      s1_re_d  = bus.I_in;
      s1_im_d  = bus.Q_in;
      s1_cos_d = cos_w;
      s1_sin_d = sin_w;
    end

    if (s1_valid_q) begin
      s2_ic_d = PW'(s1_re_q) * PW'(s1_cos_q);
      s2_qs_d = PW'(s1_im_q) * PW'(s1_sin_q);
      s2_qc_d = PW'(s1_im_q) * PW'(s1_cos_q);
      s2_is_d = PW'(s1_re_q) * PW'(s1_sin_q);
    end

    // (I + jQ) * (cos - j*sin), rounded half toward +inf.
    sum_a = SW'(s2_ic_q) + SW'(s2_qs_q);
    sum_b = SW'(s2_qc_q) - SW'(s2_is_q);
    rnd_a = (sum_a + C_RND) >>> 4;
    rnd_b = (sum_b + C_RND) >>> 4;

    if (s2_valid_q) begin
      if (rnd_a > C_MAX) begin
        i_out_d = C_MAX[DATA_W-1:0];
        sat_d   = 1'b1;
      end else if (rnd_a < C_MIN) begin
        i_out_d = C_MIN[DATA_W-1:0];
        sat_d   = 1'b1;
      end else begin
        i_out_d = rnd_a[DATA_W-1:0];
      end
      if (rnd_b > C_MAX) begin
        q_out_d = C_MAX[DATA_W-1:0];
        sat_d   = 1'b1;
      end else if (rnd_b < C_MIN) begin
        q_out_d = C_MIN[DATA_W-1:0];
        sat_d   = 1'b1;
      end else begin
        q_out_d = rnd_b[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s1_cos_q    <= '0;
      s1_sin_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_ic_q     <= '0;
      s2_qs_q     <= '0;
      s2_qc_q     <= '0;
      s2_is_q     <= '0;
      out_valid_q <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      s1_valid_q  <= s1_valid_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
      s1_cos_q    <= s1_cos_d;
      s1_sin_q    <= s1_sin_d;
      s2_valid_q  <= s2_valid_d;
      s2_ic_q     <= s2_ic_d;
      s2_qs_q     <= s2_qs_d;
      s2_qc_q     <= s2_qc_d;
      s2_is_q     <= s2_is_d;
      out_valid_q <= out_valid_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.I_out     = i_out_q;
  assign bus.Q_out     = q_out_q;
  assign bus.sat_pulse = sat_q;

endmodule
`default_nettype wire
